// File: rtl/dual_stream_adder.sv
// -----------------------------------------------------------------------------
// dual_stream_adder
//   Joins two first-word-fall-through sample FIFOs element by element: one
//   word is popped from each input FIFO, the pair is added as signed
//   two's-complement integers, and the sum is pushed into an output FIFO.
//
//   Operation is a two-state FSM:
//     S_READ  - waits until both input FIFOs hold a word, pops both together
//               and registers their sum.
//     S_WRITE - pushes the held sum as soon as the output FIFO has room.
//   One result is produced every two cycles at best. The pop strobes depend
//   only on the state and the two empty flags, so out_full never reaches
//   them combinationally.
//
//   Build option:
//     ADD_SATURATE_EN - when defined, the sum is clamped to the signed range
//                       of DATA_WIDTH instead of wrapping modulo 2^DATA_WIDTH.
//                       Timing and handshake are the same in both builds.
// -----------------------------------------------------------------------------
module dual_stream_adder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    output logic                  inA_rd_en,
    input  logic                  inA_empty,
    input  logic [DATA_WIDTH-1:0] inA_dout,

    output logic                  inB_rd_en,
    input  logic                  inB_empty,
    input  logic [DATA_WIDTH-1:0] inB_dout,

    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din
);

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sum_r;
    logic [DATA_WIDTH-1:0] sum_next;
    logic                  pair_ready;

    // A pair exists only when both heads are valid; one side alone never pops.
    assign pair_ready = !inA_empty && !inB_empty;

`ifdef ADD_SATURATE_EN
    // One guard bit above the word holds the true sign of the sum.
    logic [DATA_WIDTH:0] sum_wide;

    // Saturating add: a disagreement between the guard bit and the word's
    // sign bit means the result left the signed range; clamp toward the
    // guard bit's sign.
    always_comb begin
        sum_wide = {inA_dout[DATA_WIDTH-1], inA_dout}
                 + {inB_dout[DATA_WIDTH-1], inB_dout};
        if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
            if (sum_wide[DATA_WIDTH])
                sum_next = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            else
                sum_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            sum_next = sum_wide[DATA_WIDTH-1:0];
        end
    end
`else
    // Wrapping add: carry-out is dropped, result is modulo 2^DATA_WIDTH.
    always_comb begin
        sum_next = inA_dout + inB_dout;
    end
`endif

    // FSM and held sum: collect a pair in S_READ, deliver it from S_WRITE.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    // NOTE: sum_r is a single datapath register, so clearing it on reset is
    // cheap and keeps out_din at zero while reset is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_READ;
            sum_r <= '0;
        end else begin
            case (state)
                S_READ: begin
                    if (pair_ready) begin
                        sum_r <= sum_next;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!out_full) begin
                        state <= S_READ;
                    end
                end
                default: begin
                    state <= S_READ;
                end
            endcase
        end
    end

    // Handshake strobes: pops only in S_READ, push only in S_WRITE; all held
    // low while reset is asserted.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        inA_rd_en = 1'b0;
        inB_rd_en = 1'b0;
        out_wr_en = 1'b0;
        if (reset) begin
            case (state)
                S_READ: begin
                    inA_rd_en = pair_ready;
                    inB_rd_en = pair_ready;
                end
                S_WRITE: begin
                    out_wr_en = !out_full;
                end
                default: begin
                    out_wr_en = 1'b0;
                end
            endcase
        end
    end

    // The pushed word always comes straight from the held register.
    assign out_din = sum_r;

endmodule

// File: tb/tb_dual_stream_adder.sv
// -----------------------------------------------------------------------------
// tb_dual_stream_adder
//   Bench for dual_stream_adder. Two queue-backed FWFT FIFOs feed the DUT and
//   a scoreboard of expected sums is filled when pairs are queued, then
//   drained as the DUT pushes results. Define ADD_SATURATE_EN for both the
//   bench and the RTL to exercise the saturating build.
// -----------------------------------------------------------------------------
module tb_dual_stream_adder;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          inA_rd_en;
    logic          inA_empty;
    logic [DW-1:0] inA_dout;
    logic          inB_rd_en;
    logic          inB_empty;
    logic [DW-1:0] inB_dout;
    logic          out_wr_en;
    logic          out_full = 1'b0;
    logic [DW-1:0] out_din;

    always #5 clock = ~clock;

    dual_stream_adder #(.DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .inA_rd_en (inA_rd_en),
        .inA_empty (inA_empty),
        .inA_dout  (inA_dout),
        .inB_rd_en (inB_rd_en),
        .inB_empty (inB_empty),
        .inB_dout  (inB_dout),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .out_din   (out_din)
    );

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] exp_q[$];

    int n_cmp          = 0;
    int n_err          = 0;
    int cycle          = 0;
    int pops_a         = 0;
    int pops_b         = 0;
    int pushes         = 0;
    int last_pop_cycle = -10;
    bit lat_check      = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Golden signed add computed at full precision, then wrapped or clamped.
    function automatic logic [DW-1:0] golden(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [DW:0] w;
        w = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
`ifdef ADD_SATURATE_EN
        if (w > 33'sd2147483647)  return 32'h7FFF_FFFF;
        if (w < -33'sd2147483648) return 32'h8000_0000;
`endif
        return w[DW-1:0];
    endfunction

    task automatic drive_fifos();
        inA_empty = (qa.size() == 0);
        inA_dout  = (qa.size() != 0) ? qa[0] : '0;
        inB_empty = (qb.size() == 0);
        inB_dout  = (qb.size() != 0) ? qb[0] : '0;
    endtask

    task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] e);
        qa.push_back(a);
        qb.push_back(b);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        qa.delete();
        qb.delete();
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // FIFO and output-FIFO model: sample strobes at the edge, act 1 time unit later.
    initial begin
        logic          a_pop;
        logic          b_pop;
        logic          w;
        logic [DW-1:0] d;
        drive_fifos();
        forever begin
            @(posedge clock);
            a_pop = inA_rd_en;
            b_pop = inB_rd_en;
            w     = out_wr_en;
            d     = out_din;
            #1;
            cycle++;
            if (a_pop || b_pop) begin
                check("pop_pair_together", 32'(a_pop), 32'(b_pop));
                check("pop_from_nonempty", 32'(qa.size() != 0 && qb.size() != 0), 1);
                if (a_pop && qa.size() != 0) begin
                    void'(qa.pop_front());
                    pops_a++;
                end
                if (b_pop && qb.size() != 0) begin
                    void'(qb.pop_front());
                    pops_b++;
                end
                last_pop_cycle = cycle;
            end
            if (w) begin
                pushes++;
                if (exp_q.size() == 0)
                    check("push_without_expected_sum", exp_q.size(), 1);
                else
                    check("sum", d, exp_q.pop_front());
                if (lat_check)
                    check("pop_to_push_latency", cycle - last_pop_cycle, 1);
            end
            drive_fifos();
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1, "timeout");
    end

    // Directed sequence followed by a random soak.
    initial begin
        int pa0;
        int pb0;
        int pu0;
        int n;
        logic [DW-1:0] a;
        logic [DW-1:0] b;

        // Reset: strobes and out_din low even with a pair waiting.
        reset    = 1'b0;
        out_full = 1'b0;
        @(negedge clock);
        push_pair(32'd20, 32'd22, 32'd42);
        repeat (2) @(negedge clock);
        check("rst_inA_rd_en", 32'(inA_rd_en), 0);
        check("rst_inB_rd_en", 32'(inB_rd_en), 0);
        check("rst_out_wr_en", 32'(out_wr_en), 0);
        check("rst_out_din", out_din, 0);
        reset = 1'b1;
        wait_drain("drain_after_reset", 20);

        // Stream: each push one edge after its pop.
        @(negedge clock);
        lat_check = 1'b1;
        pu0 = pushes;
        push_pair(32'd1, 32'd2, 32'd3);
        push_pair(-32'sd5, 32'd7, 32'd2);
        push_pair(32'd100, -32'sd100, 32'd0);
        wait_drain("drain_stream", 40);
        check("stream_push_count", pushes - pu0, 3);
        lat_check = 1'b0;

        // Backpressure: one pop pair, no push while full, push 30 on release.
        @(negedge clock);
        out_full = 1'b1;
        pa0 = pops_a;
        pb0 = pops_b;
        pu0 = pushes;
        push_pair(32'd10, 32'd20, 32'd30);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_wr_en_low", 32'(out_wr_en), 0);
        end
        check("bp_pops_a", pops_a - pa0, 1);
        check("bp_pops_b", pops_b - pb0, 1);
        check("bp_no_push", pushes - pu0, 0);
        out_full = 1'b0;
        #1;
        check("bp_release_wr_en", 32'(out_wr_en), 1);
        check("bp_release_din", out_din, 32'd30);
        wait_drain("drain_bp", 10);
        check("bp_push_count", pushes - pu0, 1);

        // Starvation: A has three words, B empty.
        @(negedge clock);
        pa0 = pops_a;
        pb0 = pops_b;
        pu0 = pushes;
        qa.push_back(32'd11);
        qa.push_back(32'd12);
        qa.push_back(32'd13);
        repeat (8) @(negedge clock);
        check("starve_no_pop_a", pops_a - pa0, 0);
        check("starve_no_pop_b", pops_b - pb0, 0);
        qb.push_back(32'd4);
        exp_q.push_back(32'd15);
        wait_drain("drain_starve", 20);
        repeat (6) @(negedge clock);
        check("starve_pops_a", pops_a - pa0, 1);
        check("starve_pops_b", pops_b - pb0, 1);
        check("starve_push_count", pushes - pu0, 1);
        pulse_reset();

        // Overflow corners.
        @(negedge clock);
`ifdef ADD_SATURATE_EN
        push_pair(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF);
        push_pair(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
`else
        push_pair(32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        push_pair(32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
`endif
        wait_drain("drain_overflow", 20);

        // Reset while in S_WRITE with a push pending.
        @(negedge clock);
        out_full = 1'b1;
        pa0 = pops_a;
        push_pair(32'd5, 32'd6, 32'd11);
        n = 0;
        while (pops_a == pa0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("midrst_pair_popped", pops_a - pa0, 1);
        out_full = 1'b0;
        #1;
        check("midrst_wr_pending", 32'(out_wr_en), 1);
        reset = 1'b0;
        #1;
        check("midrst_wr_en_async", 32'(out_wr_en), 0);
        check("midrst_din_async", out_din, 0);
        exp_q.delete();
        pu0 = pushes;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("midrst_sum_never_pushed", pushes - pu0, 0);
        push_pair(-32'sd3, 32'd9, 32'd6);
        wait_drain("drain_after_midrst", 20);

        // Soak: 256 random pairs with random backpressure.
        @(negedge clock);
        pa0 = pops_a;
        for (int i = 0; i < 256; i++) begin
            a = $urandom;
            b = $urandom;
            push_pair(a, b, golden(a, b));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clock);
            out_full = ($urandom_range(0, 2) == 0);
            n++;
        end
        out_full = 1'b0;
        check("soak_drained", exp_q.size(), 0);
        check("soak_pops", pops_a - pa0, 256);

        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
